mux21_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one 2:1 mux channel between IN1 and IN2 sources. It owns the select line S, issues registered grants, and registers the selected data onto Q with a valid strobe. Every change of S is break-before-make: one dead cycle with both grants low. A hold limit bounds how long one requester can keep the channel while the other waits.

---
 rtl/mux21_arbiter_if.sv | 36 +++
 rtl/mux21_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mux21_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux21_arbiter_if.sv
// ----------------------------------------------------------------------------
// mux21_arbiter_if
// Bundles the requester-side handshake and data bus of the two-input
// round-robin mux arbiter.
//   REQ1/REQ2 : request lines, data on IN1/IN2 valid while high
//   IN1/IN2   : requester data
//   GNT1/GNT2 : registered grants
//   S         : registered mux select (0 = IN1, 1 = IN2)
//   Q/QV      : registered channel data and its update strobe
// Modports:
//   master : requester/environment side (drives REQ/IN, observes the rest)
//   slave  : arbiter side
// ----------------------------------------------------------------------------
interface mux21_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              REQ1;
    logic              REQ2;
    logic [DATA_W-1:0] IN1;
    logic [DATA_W-1:0] IN2;
    logic              GNT1;
    logic              GNT2;
    logic              S;
    logic [DATA_W-1:0] Q;
    logic              QV;

    modport master (
        output REQ1, REQ2, IN1, IN2,
        input  GNT1, GNT2, S, Q, QV
    );

    modport slave (
        input  REQ1, REQ2, IN1, IN2,
        output GNT1, GNT2, S, Q, QV
    );
endinterface

// File: rtl/mux21_arbiter.sv
// ----------------------------------------------------------------------------
// mux21_arbiter
// Two-requester round-robin arbiter owning the select of a 2:1 data mux.
// Every change of the select goes through a one-cycle dead state with both
// grants low (break-before-make). A hold limit bounds how long one side may
// keep the channel while the other side is waiting.
// Ports:
//   CLK : rising-edge clock
//   RST : synchronous active-high reset, overrides everything
//   bus : mux21_arbiter_if.slave (REQ1/REQ2, IN1/IN2 in; GNT1/GNT2, S, Q, QV out)
// Parameters:
//   DATA_W   : data width
//   MAX_HOLD : max consecutive granted cycles while the other side requests
// ----------------------------------------------------------------------------
module mux21_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 8
) (
    input logic              CLK,
    input logic              RST,
    mux21_arbiter_if.slave   bus
);
    localparam int HC_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(MAX_HOLD - 1);
    localparam logic [HC_W-1:0] HOLD_SAT = {HC_W{1'b1}};
    localparam logic [1:0]      LAST1    = 2'd1;
    localparam logic [1:0]      LAST2    = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN1   = 2'd1,
        OWN2   = 2'd2,
        SWITCH = 2'd3
    } state_t;

    state_t            state_r;
    logic              gnt1_r;
    logic              gnt2_r;
    logic              s_r;
    logic [DATA_W-1:0] q_r;
    logic              qv_r;
    logic [HC_W-1:0]   hold_cnt_r;
    logic [1:0]        last_r;

    logic              win2_s;
    logic              tgt_req_s;
    logic              at_limit_s;
    logic              beat_s;

    // Arbitration decisions derived from the current inputs and state.
    always_comb begin
        win2_s     = 1'b0;
        tgt_req_s  = 1'b0;
        at_limit_s = 1'b0;
        beat_s     = 1'b0;
        // On a tie the side that was not served last wins.
        if (bus.REQ1 && bus.REQ2) begin
            win2_s = (last_r == LAST1);
        end else begin
            win2_s = bus.REQ2;
        end
        // In SWITCH the select already holds the target side.
        if (s_r) begin
            tgt_req_s = bus.REQ2;
        end else begin
            tgt_req_s = bus.REQ1;
        end
        at_limit_s = (hold_cnt_r >= HOLD_LIM);
        beat_s     = (gnt1_r && bus.REQ1) || (gnt2_r && bus.REQ2);
    end

    // Arbiter FSM, grant/select registers and registered data channel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            gnt1_r     <= 1'b0;
            gnt2_r     <= 1'b0;
            s_r        <= 1'b0;
            q_r        <= {DATA_W{1'b0}};
            qv_r       <= 1'b0;
            hold_cnt_r <= {HC_W{1'b0}};
            last_r     <= LAST2;
        end else begin
            // Data moves only on a granted beat; otherwise Q holds.
            if (beat_s) begin
                q_r  <= s_r ? bus.IN2 : bus.IN1;
                qv_r <= 1'b1;
            end else begin
                qv_r <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (bus.REQ1 || bus.REQ2) begin
                        if (win2_s == s_r) begin
                            state_r    <= win2_s ? OWN2 : OWN1;
                            gnt1_r     <= ~win2_s;
                            gnt2_r     <= win2_s;
                            hold_cnt_r <= {HC_W{1'b0}};
                            last_r     <= win2_s ? LAST2 : LAST1;
                        end else begin
                            state_r <= SWITCH;
                            s_r     <= win2_s;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end

                SWITCH: begin
                    if (tgt_req_s) begin
                        state_r    <= s_r ? OWN2 : OWN1;
                        gnt1_r     <= ~s_r;
                        gnt2_r     <= s_r;
                        hold_cnt_r <= {HC_W{1'b0}};
                        last_r     <= s_r ? LAST2 : LAST1;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                OWN1: begin
                    // A drop and a preempt lead to the same next state.
                    if (!bus.REQ1 || (bus.REQ2 && at_limit_s)) begin
                        gnt1_r <= 1'b0;
                        if (bus.REQ2) begin
                            state_r <= SWITCH;
                            s_r     <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (hold_cnt_r != HOLD_SAT) begin
                        hold_cnt_r <= hold_cnt_r + HC_W'(1);
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end

                OWN2: begin
                    if (!bus.REQ2 || (bus.REQ1 && at_limit_s)) begin
                        gnt2_r <= 1'b0;
                        if (bus.REQ1) begin
                            state_r <= SWITCH;
                            s_r     <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (hold_cnt_r != HOLD_SAT) begin
                        hold_cnt_r <= hold_cnt_r + HC_W'(1);
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end

                default: begin
                    state_r <= IDLE;
                    gnt1_r  <= 1'b0;
                    gnt2_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.GNT1 = gnt1_r;
    assign bus.GNT2 = gnt2_r;
    assign bus.S    = s_r;
    assign bus.Q    = q_r;
    assign bus.QV   = qv_r;

endmodule

// File: tb/tb_mux21_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux21_arbiter
// Self-checking bench for mux21_arbiter (DATA_W=8, MAX_HOLD=4). A reference
// model tracks who owns the channel, whether a dead cycle is pending, the
// select, the grant streak and the last-served side, and predicts all
// outputs after every edge.
// ----------------------------------------------------------------------------
module tb_mux21_arbiter;
    localparam int DW = 8;
    localparam int MH = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   total = 0;
    int   bad   = 0;

    mux21_arbiter_if #(.DATA_W(DW)) bus ();

    mux21_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    int          m_owner;    // 0 = nobody, 1 or 2 = requester holding the channel
    bit          m_dead;     // a dead cycle toward side m_sel+1 is in progress
    int          m_sel;      // current select 0/1
    int          m_streak;   // granted cycles so far minus one
    int          m_last;     // last side served
    logic [DW-1:0] m_q;
    bit          m_qv;

    function automatic logic [DW+3:0] exp_vec();
        return {(m_owner == 1), (m_owner == 2), 1'(m_sel), m_qv, m_q};
    endfunction

    function automatic logic [DW+3:0] obs_vec();
        return {bus.GNT1, bus.GNT2, bus.S, bus.QV, bus.Q};
    endfunction

    // Advance the model with the pre-edge inputs, then let the DUT take the edge.
    task automatic tick();
        logic          rq [1:2];
        logic [DW-1:0] dd [1:2];
        int w, o, x;
        rq[1] = bus.REQ1; rq[2] = bus.REQ2;
        dd[1] = bus.IN1;  dd[2] = bus.IN2;
        if (RST) begin
            m_owner = 0; m_dead = 0; m_sel = 0; m_streak = 0;
            m_last = 2; m_q = '0; m_qv = 0;
        end else begin
            if (m_owner != 0 && rq[m_owner]) begin
                m_q = dd[m_owner]; m_qv = 1;
            end else begin
                m_qv = 0;
            end
            if (m_dead) begin
                m_dead = 0;
                if (rq[m_sel + 1]) begin
                    m_owner = m_sel + 1; m_streak = 0; m_last = m_owner;
                end
            end else if (m_owner == 0) begin
                if (rq[1] || rq[2]) begin
                    w = (rq[1] && rq[2]) ? 3 - m_last : (rq[1] ? 1 : 2);
                    if (w == m_sel + 1) begin
                        m_owner = w; m_streak = 0; m_last = w;
                    end else begin
                        m_dead = 1; m_sel = w - 1;
                    end
                end
            end else begin
                o = m_owner; x = 3 - o;
                if (!rq[o] || (rq[x] && m_streak >= MH - 1)) begin
                    m_owner = 0;
                    if (rq[x]) begin
                        m_dead = 1; m_sel = x - 1;
                    end
                end else begin
                    m_streak++;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic r1, input logic r2, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        bus.REQ1 = r1; bus.REQ2 = r2; bus.IN1 = d1; bus.IN2 = d2;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 8'hA5, 8'h5A);
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        total++;
        if (obs_vec() !== 12'h000) begin
            bad++; $display("FAIL reset_outputs got=%h want=%h", obs_vec(), 12'h000);
        end
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_model got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_req1();
        do_reset();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        drive(1'b1, 1'b0, 8'h11, 8'h00);
        tick();
        total++;
        if ({bus.GNT1, bus.GNT2, bus.S} !== 3'b100) begin
            bad++; $display("FAIL req1_grant got=%b want=100", {bus.GNT1, bus.GNT2, bus.S});
        end
        tick();
        total++;
        if ({bus.QV, bus.Q, bus.S} !== {1'b1, 8'h11, 1'b0}) begin
            bad++; $display("FAIL req1_data got qv=%b q=%h s=%b want qv=1 q=11 s=0", bus.QV, bus.Q, bus.S);
        end
        for (int i = 0; i < 3; i++) begin
            drive(i < 1, 1'b0, 8'(8'h20 + i), 8'h00);
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL req1_model got=%h want=%h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_req2();
        do_reset();
        drive(1'b0, 1'b1, 8'h00, 8'h22);
        tick();
        total++;
        if ({bus.GNT1, bus.GNT2, bus.S} !== 3'b001) begin
            bad++; $display("FAIL req2_switch got=%b want=001", {bus.GNT1, bus.GNT2, bus.S});
        end
        tick();
        total++;
        if ({bus.GNT1, bus.GNT2, bus.S} !== 3'b011) begin
            bad++; $display("FAIL req2_grant got=%b want=011", {bus.GNT1, bus.GNT2, bus.S});
        end
        tick();
        total++;
        if ({bus.QV, bus.Q} !== {1'b1, 8'h22}) begin
            bad++; $display("FAIL req2_data got qv=%b q=%h want qv=1 q=22", bus.QV, bus.Q);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL req2_model got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_hold_limit();
        int run1, run2;
        logic pg1, pg2, ps;
        do_reset();
        run1 = 0; run2 = 0; pg1 = 0; pg2 = 0; ps = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, 8'($urandom), 8'($urandom));
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL hold_model cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            total++;
            if (bus.GNT1 && bus.GNT2) begin
                bad++; $display("FAIL hold_overlap cyc=%0d got=11 want=not both", i);
            end
            if (bus.S !== ps) begin
                total++;
                if (bus.GNT1 || bus.GNT2) begin
                    bad++; $display("FAIL hold_s_change cyc=%0d grants=%b%b want=00", i, bus.GNT1, bus.GNT2);
                end
            end
            if (pg1 && !bus.GNT1) begin
                total++;
                if (run1 != MH) begin
                    bad++; $display("FAIL hold_run1 got=%0d want=%0d", run1, MH);
                end
            end
            if (pg2 && !bus.GNT2) begin
                total++;
                if (run2 != MH) begin
                    bad++; $display("FAIL hold_run2 got=%0d want=%0d", run2, MH);
                end
            end
            run1 = bus.GNT1 ? run1 + 1 : 0;
            run2 = bus.GNT2 ? run2 + 1 : 0;
            pg1 = bus.GNT1; pg2 = bus.GNT2; ps = bus.S;
        end
    endtask

    task automatic test_tie_after_last1();
        do_reset();
        drive(1'b1, 1'b0, 8'h31, 8'h00);
        tick();
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        drive(1'b1, 1'b1, 8'h41, 8'h42);
        tick();
        total++;
        if ({bus.GNT1, bus.GNT2, bus.S} !== 3'b001) begin
            bad++; $display("FAIL tie_switch got=%b want=001", {bus.GNT1, bus.GNT2, bus.S});
        end
        tick();
        total++;
        if ({bus.GNT1, bus.GNT2, bus.S} !== 3'b011) begin
            bad++; $display("FAIL tie_grant2 got=%b want=011", {bus.GNT1, bus.GNT2, bus.S});
        end
        tick();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL tie_model got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_midtransfer();
        do_reset();
        drive(1'b0, 1'b1, 8'h00, 8'h77);
        tick();
        tick();
        tick();
        total++;
        if ({bus.GNT2, bus.QV} !== 2'b11) begin
            bad++; $display("FAIL rstmid_setup got=%b want=11", {bus.GNT2, bus.QV});
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total++;
        if (obs_vec() !== 12'h000) begin
            bad++; $display("FAIL rstmid_outputs got=%h want=000", obs_vec());
        end
        drive(1'b1, 1'b1, 8'h51, 8'h52);
        tick();
        total++;
        if ({bus.GNT1, bus.GNT2, bus.S} !== 3'b100) begin
            bad++; $display("FAIL rstmid_tie got=%b want=100", {bus.GNT1, bus.GNT2, bus.S});
        end
    endtask

    task automatic test_drop();
        do_reset();
        drive(1'b0, 1'b1, 8'h00, 8'h61);
        tick();
        tick();
        drive(1'b1, 1'b1, 8'h62, 8'h63);
        tick();
        drive(1'b1, 1'b0, 8'h64, 8'h00);
        tick();
        total++;
        if ({bus.GNT1, bus.GNT2, bus.S} !== 3'b000) begin
            bad++; $display("FAIL drop_switch got=%b want=000", {bus.GNT1, bus.GNT2, bus.S});
        end
        tick();
        total++;
        if ({bus.GNT1, bus.GNT2, bus.S} !== 3'b100) begin
            bad++; $display("FAIL drop_grant1 got=%b want=100", {bus.GNT1, bus.GNT2, bus.S});
        end
        do_reset();
        drive(1'b0, 1'b1, 8'h00, 8'h71);
        tick();
        tick();
        drive(1'b1, 1'b0, 8'h72, 8'h00);
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        total++;
        if ({bus.GNT1, bus.GNT2, bus.S} !== 3'b000) begin
            bad++; $display("FAIL drop_abort got=%b want=000", {bus.GNT1, bus.GNT2, bus.S});
        end
        tick();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL drop_model got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom));
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL random_model cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        RST = 1'b0;
    endtask

    initial begin
        m_owner = 0; m_dead = 0; m_sel = 0; m_streak = 0; m_last = 2; m_q = '0; m_qv = 0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        #2;
        test_reset();
        test_req1();
        test_req2();
        test_hold_limit();
        test_tie_after_last1();
        test_reset_midtransfer();
        test_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
